// File: rtl/seq_hit_monitor.sv
// Counts upstream sequence-detector hits per fixed window of clk cycles and
// hands each window's count to a consumer over a valid/ready report port.
module seq_hit_monitor #(
  parameter int unsigned WINDOW = 64,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             z,
  input  logic             clr,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_count,
  output logic             rpt_sat,
  output logic             rpt_lost
);

  localparam int unsigned WcntW = $clog2(WINDOW);
  localparam logic [WcntW-1:0] WcntLast = WcntW'(WINDOW - 1);
  localparam logic [CNT_W-1:0] HitMax = '1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [WcntW-1:0] wcnt_q;
  logic [CNT_W-1:0] hit_q;
  logic             sat_q;

  logic             hit_at_max;
  logic [CNT_W-1:0] hit_next;
  logic             sat_next;
  logic             win_end;

  // Hit count including this cycle's z, so the last window cycle is never lost.
  always_comb begin
    hit_at_max = (hit_q == HitMax);
    hit_next   = hit_q + CNT_W'(z & ~hit_at_max);
    sat_next   = sat_q | (z & hit_at_max);
    win_end    = en & (wcnt_q == WcntLast);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      wcnt_q    <= '0;
      hit_q     <= '0;
      sat_q     <= 1'b0;
      rpt_valid <= 1'b0;
      rpt_count <= '0;
      rpt_sat   <= 1'b0;
      rpt_lost  <= 1'b0;
    end else if (clr) begin
      state_q   <= StIdle;
      wcnt_q    <= '0;
      hit_q     <= '0;
      sat_q     <= 1'b0;
      rpt_valid <= 1'b0;
      rpt_count <= '0;
      rpt_sat   <= 1'b0;
      rpt_lost  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: if (en) state_q <= StRun;
        StRun:  if (!en) state_q <= StIdle;
      endcase

      // Consumer handshake; a same-edge window end below may reload it.
      if (rpt_valid && rpt_ready) rpt_valid <= 1'b0;

      if (!en) begin
        wcnt_q <= '0;
        hit_q  <= '0;
        sat_q  <= 1'b0;
      end else if (win_end) begin
        wcnt_q <= '0;
        hit_q  <= '0;
        sat_q  <= 1'b0;
        if (!rpt_valid || rpt_ready) begin
          rpt_valid <= 1'b1;
          rpt_count <= hit_next;
          rpt_sat   <= sat_next;
        end else begin
          rpt_lost <= 1'b1;
        end
      end else begin
        wcnt_q <= wcnt_q + WcntW'(1);
        hit_q  <= hit_next;
        sat_q  <= sat_next;
      end
    end
  end

endmodule
